conv_mac_sequencer: RTL and testbench
=====================================

Name: conv_mac_sequencer

Overview:
Drives the streaming floating-point multiply-accumulate unit of the convolution datapath.
- Fetches ELEMENTS image/kernel word pairs from two synchronous-read memories (1-cycle read latency).
- Presents each pair to the MAC one per cycle, framing the accumulation with the MAC's start/clear line.
- Captures the finished accumulator value and returns it on a valid/ready result port.
- It is the controlling end of the MAC's operand/start interface and sits between the line buffers and the output writer.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width of operands and result.
- ELEMENTS, 5, operand pairs per dot product (>=1).
- ADDR_WIDTH, 8, memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- go  in  1  start request; sampled only in IDLE.
- img_base  in  ADDR_WIDTH  first image word address; captured with go.
- krn_base  in  ADDR_WIDTH  first kernel word address; captured with go.
- busy  out  1  high from first FETCH cycle until result handshake completes.
- img_addr  out  ADDR_WIDTH  image memory read address.
- krn_addr  out  ADDR_WIDTH  kernel memory read address.
- mem_rd  out  1  read strobe, high while a valid address is presented.
- img_data  in  DATA_WIDTH  image read data, valid 1 cycle after address.
- krn_data  in  DATA_WIDTH  kernel read data, valid 1 cycle after address.
- mac_a  out  DATA_WIDTH  registered MAC operand A.
- mac_b  out  DATA_WIDTH  registered MAC operand B.
- mac_start  out  1  MAC enable: 1 = accumulate, 0 = MAC clears accumulator at next edge.
- mac_c  in  DATA_WIDTH  MAC accumulator value.
- res_data  out  DATA_WIDTH  captured dot product.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.

Behaviour:
- Reset (async, any time including mid-operation):
  - State becomes IDLE.
  - All outputs are 0: addresses, mem_rd, mac_a, mac_b, mac_start, res_data, res_valid, busy.
  - mac_start=0 guarantees the MAC clears on the first clock after reset.
- States: IDLE, FETCH, DRAIN, CAPTURE, HOLD.
- IDLE -> FETCH: on go=1. img_base and krn_base are captured and the element counter is cleared.
- FETCH, N = ELEMENTS cycles:
  - Cycle k (k = 0..N-1) drives img_addr = img_base + k and krn_addr = krn_base + k, with mem_rd=1.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - After cycle N-1 the state goes to DRAIN.
- Operand pipeline:
  - A 2-stage read-valid shift (rd_v1, rd_v2) tracks the reads.
  - mac_a/mac_b load img_data/krn_data when rd_v1=1; mac_start = rd_v2.
  - Pair k is therefore on the MAC ports in cycle k+3 after the go edge. mac_start is high for exactly N consecutive cycles (3..N+2).
- DRAIN: entered after FETCH; waits until rd_v2 has fallen, then goes to CAPTURE. Full sum is visible on mac_c in cycle N+3.
- CAPTURE, 1 cycle:
  - mac_start=0.
  - res_data <= mac_c and res_valid <= 1 on the closing edge; the MAC clears on the same edge.
  - Next state is HOLD.
- HOLD:
  - res_valid and res_data stay stable until res_valid & res_ready, then go to IDLE; res_valid drops the next cycle.
  - With ELEMENTS=5, res_valid first rises in cycle 9 after the go edge.
- busy: high in FETCH, DRAIN, CAPTURE and HOLD.
- go outside IDLE: ignored; the request is not queued.
- Outside the active window, mac_a/mac_b hold their last value and mac_start=0.
- Arithmetic: none on data; this block only sequences the MAC.

Optional Feature:
- CONV_RELU_EN defined: at CAPTURE, if mac_c[DATA_WIDTH-1]=1 (negative, including -0.0), res_data is loaded with 32'h00000000; otherwise res_data = mac_c.
- Not defined: res_data = mac_c unmodified.

Decomposition:
- Shared package conv_pkg holds:
  - state enum conv_seq_state_t {IDLE, FETCH, DRAIN, CAPTURE, HOLD}.
  - FP_ZERO constant (32'h00000000).
  - FP_SIGN_BIT constant.
- One sub-module, conv_addr_gen: base registers, element counter, address adders and last-element flag.
- The FSM and operand pipeline stay in the top module.

Test Plan:
- Image = 1.0, 2.0, 3.0, 4.0, 5.0 (3F800000, 40000000, 40400000, 40800000, 40A00000); kernel all 1.0; go; res_ready=1. Required: res_valid in cycle 9, res_data = 41700000 (15.0); mac_start high cycles 3-7 only.
- Same image with kernel all -1.0 (BF800000). Required: res_data = C1700000 without CONV_RELU_EN, and 00000000 with it.
- Hold res_ready=0 for 4 cycles after res_valid; pulse go twice during HOLD. Required: res_data/res_valid stable, go ignored, exactly one result; busy drops the cycle after the handshake.
- img_base = 8'hFE, ELEMENTS=5. Required: img_addr sequence FE, FF, 00, 01, 02.
- Assert rst during FETCH cycle 2. Required: all outputs 0 asynchronously, state IDLE, MAC accumulator reads 0 after next edge; a following go produces the correct fresh sum (15.0).
- Back-to-back: second go the cycle after handshake. Required: second result is correct with no residue from the first sum.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } conv_seq_state_t;

  // IEEE-754 single +0.0 and the sign bit position within a single word
  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          FP_SIGN_BIT = 31;

  // Element counter width; a 1-element dot product still needs one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Operand address generator: latches image/kernel base addresses on load,
// steps an element counter during fetch and flags the final element.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int ELEMENTS   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [ADDR_WIDTH-1:0] img_base_i,
  input  logic [ADDR_WIDTH-1:0] krn_base_i,
  output logic [ADDR_WIDTH-1:0] img_addr_o,
  output logic [ADDR_WIDTH-1:0] krn_addr_o,
  output logic                  last_o
);

  localparam int CW = cnt_width(ELEMENTS);

  logic [ADDR_WIDTH-1:0] img_base_q, krn_base_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Counter restarts on load and advances once per fetch cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = '0;
    else if (adv_i) cnt_d = cnt_q + CW'(1);
  end

  // Base and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_base_q <= '0;
      krn_base_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (load_i) begin
        img_base_q <= img_base_i;
        krn_base_q <= krn_base_i;
      end
      cnt_q <= cnt_d;
    end
  end

  // Address sums wrap naturally at the address width
  always_comb begin
    img_addr_o = img_base_q + ADDR_WIDTH'(cnt_q);
    krn_addr_o = krn_base_q + ADDR_WIDTH'(cnt_q);
    last_o     = (cnt_q == CW'(ELEMENTS - 1));
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequencer for the streaming FP multiply-accumulate unit: fetches operand
// pairs, streams them to the MAC framed by mac_start, captures the sum and
// offers it on a valid/ready port.
// Build option: CONV_RELU_EN clamps negative results (incl. -0.0) to +0.0.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] krn_base,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] krn_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] img_data,
  input  logic [DATA_WIDTH-1:0] krn_data,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_start,
  input  logic [DATA_WIDTH-1:0] mac_c,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready
);

`ifdef CONV_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  conv_seq_state_t       state_q, state_d;
  logic                  load, last;
  logic [ADDR_WIDTH-1:0] ag_img, ag_krn;
  logic                  rd_v1_q, rd_v2_q;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_b_q;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_valid_q;

  conv_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ELEMENTS   (ELEMENTS)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .adv_i      (mem_rd),
    .img_base_i (img_base),
    .krn_base_i (krn_base),
    .img_addr_o (ag_img),
    .krn_addr_o (ag_krn),
    .last_o     (last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. DRAIN leaves once rd_v1 is clear: rd_v2 falls on that
  // same edge, so the last pair has been accumulated when CAPTURE begins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go)        state_d = FETCH;
      FETCH:   if (last)      state_d = DRAIN;
      DRAIN:   if (!rd_v1_q)  state_d = CAPTURE;
      CAPTURE:                state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // State-decoded outputs; addresses read as zero outside FETCH
  always_comb begin
    load     = (state_q == IDLE) && go;
    mem_rd   = (state_q == FETCH);
    busy     = (state_q != IDLE);
    img_addr = mem_rd ? ag_img : '0;
    krn_addr = mem_rd ? ag_krn : '0;
  end

  // Read-valid shift and operand registers; operands hold between bursts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_v2_q <= 1'b0;
      mac_a_q <= '0;
      mac_b_q <= '0;
    end else begin
      rd_v1_q <= mem_rd;
      rd_v2_q <= rd_v1_q;
      if (rd_v1_q) begin
        mac_a_q <= img_data;
        mac_b_q <= krn_data;
      end
    end
  end

  // Captured value, optionally clamped to +0.0 when the sum is negative
  always_comb begin
    res_data_d = mac_c;
    if (RELU_EN && mac_c[FP_SIGN_BIT]) res_data_d = DATA_WIDTH'(FP_ZERO);
  end

  // Result register: loaded in CAPTURE, held until the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q  <= DATA_WIDTH'(FP_ZERO);
      res_valid_q <= 1'b0;
    end else if (state_q == CAPTURE) begin
      res_data_q  <= res_data_d;
      res_valid_q <= 1'b1;
    end else if (state_q == HOLD && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // mac_start low outside the operand window makes the MAC clear
  always_comb begin
    mac_a     = mac_a_q;
    mac_b     = mac_b_q;
    mac_start = rd_v2_q;
    res_data  = res_data_q;
    res_valid = res_valid_q;
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with behavioural memories and MAC.
module tb_conv_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst, go, res_ready;
  logic [7:0]  img_base, krn_base, img_addr, krn_addr;
  logic        busy, mem_rd, mac_start, res_valid;
  logic [31:0] img_data, krn_data, mac_a, mac_b, mac_c, res_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] img_mem [256];
  logic [31:0] krn_mem [256];
  real         acc = 0.0;

`ifdef CONV_RELU_EN
  localparam logic [31:0] NEG_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] NEG_EXP = 32'hC170_0000;
`endif

  always #5 clk = ~clk;

  conv_mac_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .img_base(img_base), .krn_base(krn_base),
    .busy(busy), .img_addr(img_addr), .krn_addr(krn_addr), .mem_rd(mem_rd),
    .img_data(img_data), .krn_data(krn_data), .mac_a(mac_a), .mac_b(mac_b),
    .mac_start(mac_start), .mac_c(mac_c), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    if (mem_rd) begin
      img_data <= img_mem[img_addr];
      krn_data <= krn_mem[krn_addr];
    end
  end

  // MAC: accumulate while mac_start, clear otherwise
  always @(posedge clk) begin
    if (mac_start) acc <= acc + sp2r(mac_a) * sp2r(mac_b);
    else           acc <= 0.0;
  end
  always_comb mac_c = r2sp(acc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          vcyc, nvalid, naddr;
  logic [31:0] smask, rdat;
  logic        stable, busy_after, busy_tail, busy_c1;
  logic [7:0]  addrs [8];

  // go in the current (negedge) cycle 0, then observe up to 60 cycles
  task automatic do_run(input logic [7:0] ib, input logic [7:0] kb, input int rdly, input bit b2b);
    logic pv;
    vcyc = -1; nvalid = 0; naddr = 0; smask = '0; rdat = '0; pv = 1'b0;
    stable = 1'b1; busy_after = 1'b1; busy_tail = 1'b0; busy_c1 = 1'b0;
    img_base = ib; krn_base = kb; go = 1'b1; res_ready = (rdly == 0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin go = 1'b0; busy_c1 = busy; end
      if (c < 32) smask[c] = mac_start;
      if (mem_rd && naddr < 8) begin addrs[naddr] = img_addr; naddr++; end
      if (res_valid && !pv) nvalid++;
      pv = res_valid;
      if (res_valid && vcyc < 0) begin vcyc = c; rdat = res_data; end
      if (vcyc >= 0) begin
        if (c <= vcyc + rdly && (!res_valid || res_data !== rdat)) stable = 1'b0;
        if (rdly > 0) begin
          go = (c == vcyc + 1) || (c == vcyc + 3);
          if (c == vcyc + rdly) res_ready = 1'b1;
        end
        if (c == vcyc + rdly + 1) begin
          busy_after = busy;
          if (b2b) break;
        end
        if (c > vcyc + rdly + 1) busy_tail = busy_tail | busy;
        if (c == vcyc + rdly + 4) break;
      end
    end
    go = 1'b0;
  endtask

  initial begin
    logic [31:0] img_v [5];
    img_v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    for (int i = 0; i < 256; i++) begin img_mem[i] = '0; krn_mem[i] = '0; end
    for (int i = 0; i < 5; i++) begin
      img_mem[8'h10 + i]            = img_v[i];
      img_mem[8'(8'hFE + 8'(i))]    = img_v[i];
      krn_mem[8'h20 + i]            = 32'h3F80_0000;
      krn_mem[8'h30 + i]            = 32'hBF80_0000;
    end

    rst = 1'b1; go = 1'b0; res_ready = 1'b0; img_base = '0; krn_base = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {28'd0, busy, mem_rd, mac_start, res_valid}, 32'd0);
    chk("reset_addr", {16'd0, img_addr, krn_addr}, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic dot product 1..5 . 1 = 15.0
    do_run(8'h10, 8'h20, 0, 1'b0);
    chk("t1_busy_c1", {31'd0, busy_c1}, 32'd1);
    chk("t1_valid_cycle", vcyc, 32'd9);
    chk("t1_res_data", rdat, 32'h4170_0000);
    chk("t1_start_mask", smask, 32'h0000_00F8);
    chk("t1_addr0", {24'd0, addrs[0]}, 32'h10);
    chk("t1_addr4", {24'd0, addrs[4]}, 32'h14);
    chk("t1_busy_after", {31'd0, busy_after}, 32'd0);

    // negative sum
    do_run(8'h10, 8'h30, 0, 1'b0);
    chk("t2_res_data", rdat, NEG_EXP);

    // back-pressure with go pulses during HOLD
    do_run(8'h10, 8'h20, 4, 1'b0);
    chk("t3_res_data", rdat, 32'h4170_0000);
    chk("t3_stable", {31'd0, stable}, 32'd1);
    chk("t3_nvalid", nvalid, 32'd1);
    chk("t3_busy_after", {31'd0, busy_after}, 32'd0);
    chk("t3_go_ignored", {31'd0, busy_tail}, 32'd0);

    // address wrap
    do_run(8'hFE, 8'h20, 0, 1'b0);
    chk("t4_naddr", naddr, 32'd5);
    chk("t4_addrs", {addrs[0], addrs[1], addrs[2], addrs[3]}, 32'hFEFF_0001);
    chk("t4_addr4", {24'd0, addrs[4]}, 32'h02);
    chk("t4_res_data", rdat, 32'h4170_0000);

    // async reset in FETCH cycle 2
    img_base = 8'h10; krn_base = 8'h20; go = 1'b1; res_ready = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ctrl", {28'd0, busy, mem_rd, mac_start, res_valid}, 32'd0);
    chk("t5_addr", {16'd0, img_addr, krn_addr}, 32'd0);
    chk("t5_mac_a", mac_a, 32'd0);
    chk("t5_mac_b", mac_b, 32'd0);
    chk("t5_res_data", res_data, 32'd0);
    @(negedge clk);
    chk("t5_mac_cleared", mac_c, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_run(8'h10, 8'h20, 0, 1'b0);
    chk("t5_fresh_sum", rdat, 32'h4170_0000);
    chk("t5_valid_cycle", vcyc, 32'd9);

    // back-to-back: second go the cycle after the handshake
    do_run(8'h10, 8'h30, 0, 1'b1);
    chk("t6_first", rdat, NEG_EXP);
    do_run(8'h10, 8'h20, 0, 1'b0);
    chk("t6_second", rdat, 32'h4170_0000);
    chk("t6_valid_cycle", vcyc, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
